gps_clk_monitor: RTL and testbench
==================================

// Module: gps_clk_monitor
// PURPOSE
//   Consumer-side checker for the GPS clock/reset generator outputs. Samples one
//   generated clock (normally the slow GPS clock) and its generated reset.
//   Measures the clock period in reference-clock cycles and declares lock after
//   consecutive in-tolerance periods. Flags period errors and dead clocks for the
//   SoC status registers.
// PARAMETERS
//   CNT_W      16   width of the period counter and the period output
//   EXP_PERIOD 100  expected mon_clk period, in clk cycles
//   TOL        2    allowed +/- deviation from EXP_PERIOD, in clk cycles
//   LOCK_COUNT 4    consecutive good periods required to assert locked
//   TIMEOUT    200  clk cycles without a mon_clk rise that count as a dead clock (< 2^CNT_W-1)
// PORTS
//   clk          in   1      reference clock; all logic is on this clock
//   rst          in   1      asynchronous, active-high reset
//   mon_clk      in   1      monitored clock, asynchronous to clk; period >= 4 clk cycles
//   mon_rst      in   1      monitored reset, asynchronous, active-high
//   fault_clr    in   1      1-cycle pulse; clears fault
//   period       out  CNT_W  last measured period, in clk cycles
//   period_valid out  1      1-cycle pulse when period updates
//   locked       out  1      LOCK_COUNT consecutive good periods seen, none bad since
//   fault        out  1      sticky; set by a bad period or a timeout
//   fault_cnt    out  8      fault events; saturates at 255; cleared only by rst
// BEHAVIOUR
// - Synchronisers and reset values
//   - mon_clk and mon_rst each pass through a 2-flop synchroniser (s1,s2).
//   - mon_clk has a third flop s3; rise = s2 & ~s3.
//   - A mon_clk rising edge gives rise 3 clk edges later, +/-1 for sampling.
//   - On rst, all flops clear: period=0, period_valid=0, locked=0, fault=0,
//     fault_cnt=0, state=IDLE.
// - Counter cnt
//   - Cleared to 1 on rise; otherwise increments, saturating at all-ones.
//   - At each rise, cnt equals the number of clk cycles since the previous rise.
// - FSM
//   - IDLE: entered while synced mon_rst=1, from any state, regardless of other
//     events. No fault is raised here. locked=0, good_cnt=0.
//     Moves to SYNC on the first cycle synced mon_rst=0.
//   - SYNC: waits for the first rise. No measurement is taken. On rise: cnt=1,
//     go to MEAS. Timeout is disabled in SYNC.
//   - MEAS / LOCKED, on rise:
//     - period<=cnt and period_valid=1 on the next cycle.
//     - good when EXP_PERIOD-TOL <= cnt <= EXP_PERIOD+TOL.
//     - good: good_cnt++ (saturates at LOCK_COUNT). When it reaches LOCK_COUNT,
//       go to LOCKED and set locked=1 in the same cycle as period_valid.
//     - bad: fault event, good_cnt=0, locked=0, stay in or return to MEAS.
//       The bad period is still reported on period/period_valid.
//   - MEAS / LOCKED, timeout: cnt==TIMEOUT with no rise gives a fault event,
//     locked=0, good_cnt=0, go to SYNC. No period_valid.
//   - A timeout is raised only once per dead interval.
// - Fault event
//   - fault<=1 and fault_cnt<=sat(fault_cnt+1).
//   - fault_clr in the same cycle as an event: the event wins and fault stays 1.
//   - fault_clr with no event: fault<=0 next cycle. fault_cnt is unchanged.
// - Outputs are registered; there are no combinational paths from inputs to outputs.
// - rst asserted mid-measurement aborts immediately. After release the block
//   restarts in IDLE and needs a fresh SYNC.
// TESTING
//   T1 mon_clk toggles every 50 clk, mon_rst=0 -> period_valid every 100 clk,
//      period=100; locked=1 at the 4th valid after the first rise; fault=0.
//   T2 lock as in T1, then a single period of 103 clk -> period=103, locked=0,
//      fault=1, fault_cnt=1; relocks after 4 further 100-clk periods; fault stays 1.
//   T3 lock, then hold mon_clk low -> fault=1, fault_cnt+1 exactly 200 clk after
//      the last rise; one event only; state SYNC; restart mon_clk -> relock.
//   T4 lock, assert mon_rst for 10 clk -> locked=0 within 3 clk; no fault; after
//      release, first rise gives no period_valid; locked again after 4 good periods.
//   T5 fault_clr on the same cycle as a bad-period event -> fault=1; fault_clr
//      alone later -> fault=0; inject 300 bad periods -> fault_cnt=255.
//   T6 pulse rst mid-period while locked -> all outputs 0 asynchronously;
//      normal lock sequence after release.

Source files
------------

// File: rtl/gps_clk_monitor.sv
// Consumer-side checker for a generated clock/reset pair: measures the monitored
// clock period in reference cycles, declares lock, and flags bad periods and dead clocks.
module gps_clk_monitor #(
   parameter int CNT_W      = 16,
   parameter int EXP_PERIOD = 100,
   parameter int TOL        = 2,
   parameter int LOCK_COUNT = 4,
   parameter int TIMEOUT    = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mon_clk,
   input  logic             mon_rst,
   input  logic             fault_clr,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic             fault,
   output logic [7:0]       fault_cnt
);

   localparam int               GW       = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] LO_LIM   = CNT_W'(EXP_PERIOD - TOL);
   localparam logic [CNT_W-1:0] HI_LIM   = CNT_W'(EXP_PERIOD + TOL);
   localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
   localparam logic [GW-1:0]    LOCK_VAL = GW'(LOCK_COUNT);
   localparam logic [GW-1:0]    LOCK_M1  = GW'(LOCK_COUNT - 1);

   typedef enum logic [1:0] {IDLE, SYNC, MEAS, LOCKED} state_t;

   state_t           state;
   logic             mclk_s1, mclk_s2, mclk_s3;
   logic             mrst_s1, mrst_s2;
   logic             rise;
   logic [CNT_W-1:0] cnt;
   logic [GW-1:0]    good_cnt;
   logic             measuring;
   logic             in_tol;
   logic             bad_evt;
   logic             timeout_evt;
   logic             fault_evt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mclk_s1 <= 1'b0;
         mclk_s2 <= 1'b0;
         mclk_s3 <= 1'b0;
         mrst_s1 <= 1'b0;
         mrst_s2 <= 1'b0;
      end else begin
         mclk_s1 <= mon_clk;
         mclk_s2 <= mclk_s1;
         mclk_s3 <= mclk_s2;
         mrst_s1 <= mon_rst;
         mrst_s2 <= mrst_s1;
      end
   end

   assign rise = mclk_s2 & ~mclk_s3;

   // Restarting at 1 makes cnt equal the rise-to-rise distance when the next rise arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (rise) begin
         cnt <= CNT_W'(1);
      end else if (cnt != '1) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign measuring   = (state == MEAS) || (state == LOCKED);
   assign in_tol      = (cnt >= LO_LIM) && (cnt <= HI_LIM);
   assign bad_evt     = ~mrst_s2 & measuring & rise & ~in_tol;
   assign timeout_evt = ~mrst_s2 & measuring & ~rise & (cnt == TO_VAL);
   assign fault_evt   = bad_evt | timeout_evt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         good_cnt     <= '0;
      end else begin
         period_valid <= 1'b0;
         if (mrst_s2) begin
            state    <= IDLE;
            locked   <= 1'b0;
            good_cnt <= '0;
         end else begin
            case (state)
               IDLE: state <= SYNC;
               SYNC: if (rise) state <= MEAS;
               MEAS, LOCKED: begin
                  if (rise) begin
                     period       <= cnt;
                     period_valid <= 1'b1;
                     if (in_tol) begin
                        if (good_cnt >= LOCK_M1) begin
                           good_cnt <= LOCK_VAL;
                           state    <= LOCKED;
                           locked   <= 1'b1;
                        end else begin
                           good_cnt <= good_cnt + GW'(1);
                        end
                     end else begin
                        good_cnt <= '0;
                        locked   <= 1'b0;
                        state    <= MEAS;
                     end
                  end else if (cnt == TO_VAL) begin
                     // Dropping back to SYNC disarms the timeout, so a dead clock reports once.
                     good_cnt <= '0;
                     locked   <= 1'b0;
                     state    <= SYNC;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // A fault event takes priority over a simultaneous clear request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault     <= 1'b0;
         fault_cnt <= 8'd0;
      end else if (fault_evt) begin
         fault <= 1'b1;
         if (fault_cnt != 8'hFF) begin
            fault_cnt <= fault_cnt + 8'd1;
         end
      end else if (fault_clr) begin
         fault <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gps_clk_monitor.sv
// Randomized bench for gps_clk_monitor: mon_clk rises are placed at exact clk-cycle
// distances and every period report is compared with an event-level model.
module tb_gps_clk_monitor;

   localparam int CNT_W      = 16;
   localparam int EXP_PERIOD = 100;
   localparam int TOL        = 2;
   localparam int LOCK_COUNT = 4;
   localparam int TIMEOUT    = 200;

   logic             clk = 1'b0;
   logic             rst;
   logic             mon_clk;
   logic             mon_rst;
   logic             fault_clr;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             locked;
   logic             fault;
   logic [7:0]       fault_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int p;
      int lk;
      int flt;
      int fcnt;
   } report_t;

   report_t exp_q[$];

   int have_ref;
   int good_run;
   int m_locked;
   int m_fault;
   int m_fault_cnt;
   int last_evt;
   int bnd[6] = '{97, 98, 102, 103, 199, 200};

   always #5 clk = ~clk;

   gps_clk_monitor #(
      .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .TOL(TOL),
      .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .mon_clk(mon_clk), .mon_rst(mon_rst),
      .fault_clr(fault_clr), .period(period), .period_valid(period_valid),
      .locked(locked), .fault(fault), .fault_cnt(fault_cnt)
   );

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic modelReset();
      have_ref    = 0;
      good_run    = 0;
      m_locked    = 0;
      m_fault     = 0;
      m_fault_cnt = 0;
      last_evt    = 0;
   endtask

   task automatic modelEvent();
      m_fault = 1;
      if (m_fault_cnt < 255) m_fault_cnt++;
   endtask

   task automatic modelRise(input int p);
      report_t r;
      if (have_ref == 0) begin
         have_ref = 1;
         last_evt = 0;
      end else begin
         if (p >= EXP_PERIOD - TOL && p <= EXP_PERIOD + TOL) begin
            if (good_run < LOCK_COUNT) good_run++;
            m_locked = (good_run == LOCK_COUNT) ? 1 : 0;
            last_evt = 0;
         end else begin
            modelEvent();
            good_run = 0;
            m_locked = 0;
            last_evt = 1;
         end
         r.p    = p;
         r.lk   = m_locked;
         r.flt  = m_fault;
         r.fcnt = m_fault_cnt;
         exp_q.push_back(r);
      end
   endtask

   // Next mon_clk rise lands exactly p clk cycles after the previous one.
   // clr_mode 1: fault_clr coincides with the event of the previous rise; 2: clear mid-period.
   task automatic applyStimulus(input int p, input int clr_mode, input bit do_rst);
      bit dead;
      bit dead_done;
      dead      = (have_ref != 0) && (p > TIMEOUT);
      dead_done = 1'b0;
      for (int c = 1; c <= p; c++) begin
         @(negedge clk);
         if (c == p / 2) mon_clk = 1'b0;
         if (clr_mode == 1 && c == 2) begin
            fault_clr = 1'b1;
            if (last_evt == 0) m_fault = 0;
         end
         if (clr_mode == 1 && c == 3) fault_clr = 1'b0;
         if (clr_mode == 1 && c == 4) checkOutput("clr_vs_event", int'(fault), m_fault);
         if (clr_mode == 2 && c == p / 4) begin
            fault_clr = 1'b1;
            m_fault   = 0;
         end
         if (clr_mode == 2 && c == p / 4 + 1) fault_clr = 1'b0;
         if (clr_mode == 2 && c == p / 4 + 2) checkOutput("clr_alone", int'(fault), m_fault);
         if (dead && c == TIMEOUT + 2) begin
            checkOutput("timeout_early", int'(fault_cnt), m_fault_cnt);
            modelEvent();
            have_ref  = 0;
            good_run  = 0;
            m_locked  = 0;
            dead_done = 1'b1;
         end
         if (dead && c == TIMEOUT + 3) begin
            checkOutput("timeout_cnt", int'(fault_cnt), m_fault_cnt);
            checkOutput("timeout_fault", int'(fault), m_fault);
            checkOutput("timeout_locked", int'(locked), m_locked);
         end
         if (do_rst && c == (3 * p) / 4) begin
            checkOutput("pre_rst_locked", int'(locked), m_locked);
            #1 rst = 1'b1;
            #1;
            checkOutput("rst_period", int'(period), 0);
            checkOutput("rst_valid", int'(period_valid), 0);
            checkOutput("rst_locked", int'(locked), 0);
            checkOutput("rst_fault", int'(fault), 0);
            checkOutput("rst_fault_cnt", int'(fault_cnt), 0);
            modelReset();
            #1 rst = 1'b0;
         end
         if (c == p) begin
            if (dead && !dead_done) begin
               modelEvent();
               have_ref = 0;
               good_run = 0;
               m_locked = 0;
            end
            mon_clk = 1'b1;
            modelRise(p);
         end
      end
   endtask

   task automatic monReset(input int n);
      repeat (10) @(negedge clk);
      mon_rst  = 1'b1;
      have_ref = 0;
      good_run = 0;
      m_locked = 0;
      last_evt = 0;
      repeat (3) @(negedge clk);
      checkOutput("monrst_locked", int'(locked), m_locked);
      checkOutput("monrst_fault_cnt", int'(fault_cnt), m_fault_cnt);
      repeat (n - 3) @(negedge clk);
      mon_rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst && period_valid) begin
         report_t r;
         if (exp_q.size() == 0) begin
            checkOutput("spurious_valid", int'(period_valid), 0);
         end else begin
            r = exp_q.pop_front();
            checkOutput("period", int'(period), r.p);
            checkOutput("locked", int'(locked), r.lk);
            checkOutput("fault", int'(fault), r.flt);
            checkOutput("fault_cnt", int'(fault_cnt), r.fcnt);
         end
      end
   end

   initial begin
      int p;
      int r;
      int mode;
      rst       = 1'b1;
      mon_clk   = 1'b0;
      mon_rst   = 1'b0;
      fault_clr = 1'b0;
      modelReset();
      repeat (3) @(negedge clk);
      checkOutput("reset_period", int'(period), 0);
      checkOutput("reset_valid", int'(period_valid), 0);
      checkOutput("reset_locked", int'(locked), 0);
      checkOutput("reset_fault", int'(fault), 0);
      checkOutput("reset_fault_cnt", int'(fault_cnt), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] nominal lock");
      repeat (6) applyStimulus(100, 0, 1'b0);
      $display("[TB] single long period and relock");
      applyStimulus(103, 0, 1'b0);
      repeat (4) applyStimulus(100, 0, 1'b0);
      $display("[TB] dead clock");
      applyStimulus(250, 0, 1'b0);
      repeat (5) applyStimulus(100, 0, 1'b0);
      $display("[TB] monitored reset");
      monReset(10);
      repeat (5) applyStimulus(100, 0, 1'b0);
      $display("[TB] fault clear and saturation");
      applyStimulus(103, 0, 1'b0);
      applyStimulus(100, 1, 1'b0);
      applyStimulus(100, 2, 1'b0);
      repeat (300) applyStimulus(10, 0, 1'b0);
      repeat (5) applyStimulus(100, 0, 1'b0);
      $display("[TB] reset while locked");
      applyStimulus(100, 0, 1'b1);
      repeat (6) applyStimulus(100, 0, 1'b0);

      $display("[TB] randomized periods");
      for (int i = 0; i < 150; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 65)      p = int'($urandom_range(EXP_PERIOD - TOL - 1, EXP_PERIOD + TOL + 1));
         else if (r < 80) p = int'($urandom_range(8, 200));
         else if (r < 90) p = bnd[$urandom_range(0, 5)];
         else             p = int'($urandom_range(205, 260));
         r    = int'($urandom_range(0, 9));
         mode = 0;
         if (r == 0 && last_evt != 0) mode = 1;
         else if (r == 1 && p >= 40)  mode = 2;
         if ($urandom_range(0, 19) == 0) monReset(int'($urandom_range(5, 30)));
         applyStimulus(p, mode, 1'b0);
      end

      repeat (10) @(negedge clk);
      checkOutput("pending_reports", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
